vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Raster timing generator that sits directly downstream of the VGA clock divider.
- Samples the divider's square-wave output (pix_clk_in) in the system clock domain and converts each rising edge into a one-cycle pixel strobe.
- Runs horizontal/vertical counters on that strobe and produces registered hsync, vsync, video_on, pixel coordinates and frame/line markers.
- Feeds the pixel-colour logic and the VGA connector pins; default timing is 640x480@60 (50 MHz clk, divider at 25 MHz).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
pix_clk_in  in  1  divided clock from the divider stage, synchronous to clk
pix_stb  out  1  one-clk pulse per pixel; counters advance on this cycle's edge
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
video_on  out  1  high while h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
pix_x  out  10  current h_cnt
pix_y  out  10  current v_cnt
line_end  out  1  one-clk pulse when h_cnt wraps to 0
frame_start  out  1  one-clk pulse when (h_cnt, v_cnt) wraps to (0, 0)

Behaviour:
- Edge detect:
  - pix_prev <= pix_clk_in every clk.
  - stb = pix_clk_in & ~pix_prev.
  - pix_prev resets to 1, so a high input at reset release produces no strobe until a genuine 0->1 transition.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525).
- Both totals must be <= 1024 (10-bit counters). Violations are flagged by an elaboration-time assertion.
- On an edge with stb = 1:
  - h_cnt = H_TOTAL-1 -> h_cnt <= 0, then:
    - v_cnt = V_TOTAL-1 -> v_cnt <= 0.
    - otherwise v_cnt <= v_cnt+1.
  - otherwise h_cnt <= h_cnt+1.
- With stb = 0, the counters hold.
- All outputs are registered, decoded from the next counter values, so they change on the same clk edge as the counters (zero added latency).
- hsync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
- vsync is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491].
- pix_stb registered is stb delayed by one clk: it is high in the cycle after the counter update and marks the new pixel as valid.
- line_end and frame_start are high for exactly one clk, coincident with pix_stb, on the corresponding wrap.
- Reset (asynchronous, any time including mid-frame):
  - h_cnt = v_cnt = 0, pix_x = pix_y = 0.
  - hsync = vsync = inactive (~SYNC_POL).
  - video_on = 1 (decode of (0, 0)).
  - pix_stb = line_end = frame_start = 0.
- pix_clk_in stuck (high or low): counters and outputs freeze. This is not an error.
- pix_clk_in toggling every clk (divider disabled/misconfigured): one strobe every 2 clk. Behaviour stays well-defined.

Decomposition:
- Package vga_timing_pkg:
  - CNT_W = 10.
  - Default 640x480 timing constants.
  - typedef logic [CNT_W-1:0] vga_cnt_t.
- One sub-module, vga_tick_detect:
  - Ports clk, rst_n, level_in, tick_out.
  - Rising-edge detector with the reset-to-1 rule above.
- Counters and decode stay in vga_sync_gen.

Test Plan:
- Reset with pix_clk_in held at 1, release, hold at 1 for 20 clk -> pix_stb never asserts; pix_x = 0, pix_y = 0, hsync = vsync = 1, video_on = 1.
- Drive pix_clk_in as 25 MHz square (2 clk period), run 800 strobes -> line_end pulses exactly once, at the strobe where pix_x returns to 0; pix_y = 1.
- Same stimulus, monitor one line -> hsync low for exactly 96 strobes, beginning at pix_x = 656; video_on low from pix_x = 640 to 799.
- Run a full frame (420000 strobes) -> vsync low for pix_y 490-491 (1600 strobes); frame_start pulses once, at the (799, 524) -> (0, 0) wrap.
- Assert rst_n low asynchronously at pix_x = 300, pix_y = 200 (mid-clk) -> outputs immediately take reset values; the first strobe after release gives pix_x = 1.
- Stop pix_clk_in for 50 clk mid-line at pix_x = 100 -> pix_x, hsync and video_on hold; counting resumes at 101 on the next rising edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster-timing constants, counter type and window decode helper for the VGA sync path.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int unsigned CNT_W         = 10;
    localparam int unsigned CNT_MAX_TOTAL = 1 << CNT_W;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef logic [CNT_W-1:0] vga_cnt_t;

    // True when lo <= cnt < lo + len; len = 0 gives an empty window.
    function automatic logic in_window(vga_cnt_t cnt, int unsigned lo, int unsigned len);
        int unsigned c;
        c = 32'(cnt);
        return (c >= lo) && (c < lo + len);
    endfunction

endpackage

// File: rtl/vga_tick_detect.sv
// Rising-edge detector for the divided pixel clock, sampled in the system clock domain.
// The history bit resets high so a level already high at reset release yields no tick.
module vga_tick_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic tick_out
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_in;
        end
    end

    assign tick_out = level_in & ~prev_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: turns pixel-clock edges into strobes and drives registered
// sync, blanking, coordinate and line/frame markers decoded from the next counter values.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_clk_in,
    output logic             pix_stb,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_end,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_timing
        $fatal(1, "vga_sync_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
    end

    localparam vga_cnt_t H_LAST = vga_cnt_t'(H_TOTAL - 1);
    localparam vga_cnt_t V_LAST = vga_cnt_t'(V_TOTAL - 1);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;

    logic     stb;
    vga_cnt_t h_q, h_d;
    vga_cnt_t v_q, v_d;
    logic     h_wrap, v_wrap;
    logic     hs_act_d, vs_act_d, video_on_d;

    vga_tick_detect u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .level_in (pix_clk_in),
        .tick_out (stb)
    );

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        if (stb) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + vga_cnt_t'(1);
            end else begin
                h_d = h_q + vga_cnt_t'(1);
            end
        end
    end

    // Decode from the next counter values so outputs move on the same edge as the counters.
    always_comb begin
        hs_act_d   = in_window(h_d, HS_START, H_SYNC);
        vs_act_d   = in_window(v_d, VS_START, V_SYNC);
        video_on_d = in_window(h_d, 0, H_ACTIVE) && in_window(v_d, 0, V_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
            pix_stb     <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b1;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            pix_stb     <= stb;
            hsync       <= hs_act_d ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act_d ? SYNC_POL : ~SYNC_POL;
            video_on    <= video_on_d;
            line_end    <= stb & h_wrap;
            frame_start <= stb & h_wrap & v_wrap;
        end
    end

    assign pix_x = h_q;
    assign pix_y = v_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster, checked against a linear pixel-index model.
module tb_vga_sync_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int TOT = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_clk_in = 1'b1;
    logic       pix_stb, hsync, vsync, video_on, line_end, frame_start;
    logic [9:0] pix_x, pix_y;

    vga_sync_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_clk_in  (pix_clk_in),
        .pix_stb     (pix_stb),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .line_end    (line_end),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Model: position is a linear pixel index advanced by each 0->1 input transition.
    int   p = 0;
    logic m_prev = 1'b1;
    logic m_stb = 1'b0;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_stb = 0, n_le = 0, n_fs = 0, n_hs = 0, n_vs = 0, n_voff = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int x, y;
        x = p % HT;
        y = p / HT;
        chk("pix_x", pix_x, x);
        chk("pix_y", pix_y, y);
        chk("hsync", hsync, (x >= HA + HF && x < HA + HF + HS) ? 0 : 1);
        chk("vsync", vsync, (y >= VA + VF && y < VA + VF + VS) ? 0 : 1);
        chk("video_on", video_on, (x < HA && y < VA) ? 1 : 0);
        chk("pix_stb", pix_stb, m_stb);
        chk("line_end", line_end, (m_stb && x == 0) ? 1 : 0);
        chk("frame_start", frame_start, (m_stb && p == 0) ? 1 : 0);
    endtask

    task automatic clear_counts();
        n_stb = 0; n_le = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_voff = 0;
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        pix_clk_in = v;
        @(posedge clk);
        m_stb  = v & ~m_prev;
        m_prev = v;
        if (m_stb) p = (p + 1) % TOT;
        #1;
        check_all();
        if (pix_stb) begin
            n_stb++;
            if (line_end) n_le++;
            if (frame_start) n_fs++;
            if (!hsync) n_hs++;
            if (!vsync) n_vs++;
            if (!video_on) n_voff++;
        end
    endtask

    task automatic model_reset();
        p = 0; m_prev = 1'b1; m_stb = 1'b0;
    endtask

    task automatic run_until(input int tx, input int ty);
        int budget = 2 * TOT;
        while (!((p % HT) == tx && (p / HT) == ty) && budget > 0) begin
            drive(1'b0);
            drive(1'b1);
            budget--;
        end
        chk("reach_x", pix_x, tx);
        chk("reach_y", pix_y, ty);
    endtask

    initial begin
        // Reset with input high, then hold high: no strobe may appear.
        rst_n = 1'b0;
        pix_clk_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        repeat (20) drive(1'b1);
        chk("no_stb_when_high", n_stb, 0);

        // One line of square wave.
        clear_counts();
        for (int i = 0; i < HT; i++) begin
            drive(1'b0);
            drive(1'b1);
        end
        chk("line_strobes", n_stb, HT);
        chk("line_end_count", n_le, 1);
        chk("line_pix_y", pix_y, 1);
        chk("line_hsync_len", n_hs, HS);
        chk("line_blank_len", n_voff, VT > 1 ? HT - HA : HT);

        // Full frame from here returns to the same position, wrapping once.
        clear_counts();
        for (int i = 0; i < TOT; i++) begin
            drive(1'b0);
            drive(1'b1);
        end
        chk("frame_start_count", n_fs, 1);
        chk("frame_vsync_len", n_vs, VS * HT);
        chk("frame_line_ends", n_le, VT);

        // Random input levels.
        for (int i = 0; i < 1500; i++) drive(1'($urandom_range(0, 1)));

        // Input toggling every clk: one strobe per two clk.
        clear_counts();
        drive(1'b0);
        clear_counts();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1);
            drive(1'b0);
        end
        chk("fast_toggle_strobes", n_stb, 100);

        // Stuck input mid-line: everything holds, then resumes at the next pixel.
        run_until(10, 3);
        clear_counts();
        repeat (50) drive(1'b1);
        chk("stuck_strobes", n_stb, 0);
        chk("stuck_hold_x", pix_x, 10);
        drive(1'b0);
        drive(1'b1);
        chk("resume_x", pix_x, 11);

        // Asynchronous reset between clock edges mid-frame.
        run_until(20, 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
        drive(1'b0);
        drive(1'b1);
        chk("post_reset_x", pix_x, 1);
        chk("post_reset_y", pix_y, 0);

        // Random tail to exercise wraps after reset.
        for (int i = 0; i < 1200; i++) drive(1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
